// File: rtl/integ_pkg.sv
// Shared types and the saturating clamp helper for the multi-channel integrator.
package integ_pkg;

    // Internal clamp width; covers accumulators up to 64 bits.
    localparam int unsigned CLAMP_W = 64;

    typedef enum logic [1:0] {
        OP_ADD   = 2'b00,
        OP_LOAD  = 2'b01,
        OP_CLEAR = 2'b10,
        OP_READ  = 2'b11
    } op_e;

    typedef enum logic {
        ST_SWEEP = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    typedef struct packed {
        logic [CLAMP_W-1:0] result;
        logic               hi;
        logic               lo;
    } clamp_t;

    // Clamp a signed value into [-eff_lim, +eff_lim]; touching the bound is not saturation.
    function automatic clamp_t sat_clamp(input logic [CLAMP_W:0] value, input logic [CLAMP_W-1:0] eff_lim);
        clamp_t                    r;
        logic signed [CLAMP_W:0]   v;
        logic signed [CLAMP_W:0]   pos;
        logic signed [CLAMP_W:0]   neg;
        v   = $signed(value);
        pos = $signed({1'b0, eff_lim});
        neg = -pos;
        r   = '0;
        if (v > pos) begin
            r.result = pos[CLAMP_W-1:0];
            r.hi     = 1'b1;
        end else if (v < neg) begin
            r.result = neg[CLAMP_W-1:0];
            r.lo     = 1'b1;
        end else begin
            r.result = v[CLAMP_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/sat_clamp_unit.sv
// Combinational ACC_W+1 -> ACC_W saturating clamp with hi/lo flags.
module sat_clamp_unit
    import integ_pkg::*;
#(
    parameter int unsigned ACC_W = 32
) (
    input  logic [ACC_W:0]   i_value,
    input  logic [ACC_W-2:0] i_eff_lim,
    output logic [ACC_W-1:0] o_result_c,
    output logic             o_hi_c,
    output logic             o_lo_c
);

    logic signed [ACC_W:0] w_value_s;
    clamp_t                w_res;

    // Sign-extend into the helper's width and clamp; the result always fits ACC_W.
    assign w_value_s  = $signed(i_value);
    assign w_res      = sat_clamp((CLAMP_W+1)'(w_value_s), CLAMP_W'(i_eff_lim));
    assign o_result_c = ACC_W'(w_res.result);
    assign o_hi_c     = w_res.hi;
    assign o_lo_c     = w_res.lo;

    // Upper helper bits are only sign copies of the in-band result.
    generate
        if (ACC_W < CLAMP_W) begin : g_unused
            logic w_unused_hi;
            assign w_unused_hi = ^w_res.result[CLAMP_W-1:ACC_W];
        end
    endgenerate

endmodule

// File: rtl/sat_integrator_mc.sv
// Multi-channel signed saturating integrator, time-shared on one adder/clamp.
module sat_integrator_mc
    import integ_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ACC_W  = 32,
    parameter int unsigned NUM_CH = 4,
    // One extra code point so out-of-range channel numbers are representable.
    parameter int unsigned CH_W   = $clog2(NUM_CH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CH_W-1:0]   in_ch,
    input  logic [1:0]        in_op,
    input  logic [DATA_W-1:0] in_delta,
    input  logic [ACC_W-2:0]  limit,
    input  logic              clear_all,
    output logic              out_valid,
    output logic [CH_W-1:0]   out_ch,
    output logic [ACC_W-1:0]  out_result,
    output logic              out_sat_hi,
    output logic              out_sat_lo
);

    localparam int unsigned    IDX_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CH_W-1:0] LAST_IDX = CH_W'(NUM_CH - 1);
    localparam logic [CH_W-1:0] NUM_CH_C = CH_W'(NUM_CH);

    state_e                 r_state;
    state_e                 w_state_next;
    logic [CH_W-1:0]        r_sweep_idx;
    logic [CH_W-1:0]        w_sweep_idx_next;
    logic                   w_sweep_we;

    logic [ACC_W-1:0]       r_acc [NUM_CH];

    logic                   r_out_valid;
    logic [CH_W-1:0]        r_out_ch;
    logic [ACC_W-1:0]       r_out_result;
    logic                   r_out_sat_hi;
    logic                   r_out_sat_lo;

    op_e                    w_op;
    logic                   w_xfer;
    logic                   w_ch_ok;
    logic                   w_hit;
    logic [IDX_W-1:0]       w_idx;
    logic [IDX_W-1:0]       w_sweep_addr;
    logic [ACC_W-1:0]       w_acc_rd;
    logic signed [ACC_W:0]  w_acc_ext;
    logic signed [ACC_W:0]  w_delta_ext;
    logic signed [ACC_W:0]  w_sum;
    logic signed [ACC_W:0]  w_operand;
    logic [ACC_W-1:0]       w_clamp_res;
    logic                   w_clamp_hi;
    logic                   w_clamp_lo;
    logic [ACC_W-1:0]       w_new;
    logic                   w_new_hi;
    logic                   w_new_lo;
    logic                   w_write;

    // FSM state register: sweep position restarts on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_SWEEP;
            r_sweep_idx <= '0;
        end else begin
            r_state     <= w_state_next;
            r_sweep_idx <= w_sweep_idx_next;
        end
    end

    // FSM next state: sweep every channel once, clear_all always restarts the sweep.
    always_comb begin
        w_state_next     = r_state;
        w_sweep_idx_next = r_sweep_idx;
        case (r_state)
            ST_SWEEP: begin
                if (clear_all) begin
                    w_sweep_idx_next = '0;
                end else if (r_sweep_idx == LAST_IDX) begin
                    w_state_next     = ST_RUN;
                    w_sweep_idx_next = '0;
                end else begin
                    w_sweep_idx_next = r_sweep_idx + CH_W'(1);
                end
            end
            ST_RUN: begin
                if (clear_all) begin
                    w_state_next     = ST_SWEEP;
                    w_sweep_idx_next = '0;
                end
            end
            default: begin
                w_state_next     = ST_SWEEP;
                w_sweep_idx_next = '0;
            end
        endcase
    end

    // FSM outputs: ready only while running and not being cleared.
    always_comb begin
        in_ready   = 1'b0;
        w_sweep_we = 1'b0;
        case (r_state)
            ST_SWEEP: w_sweep_we = 1'b1;
            ST_RUN:   in_ready   = ~clear_all;
            default:  ;
        endcase
    end

    assign w_op         = op_e'(in_op);
    assign w_xfer       = in_valid & in_ready;
    assign w_ch_ok      = (in_ch < NUM_CH_C);
    assign w_hit        = w_xfer & w_ch_ok;
    assign w_idx        = IDX_W'(in_ch);
    assign w_sweep_addr = IDX_W'(r_sweep_idx);
    assign w_acc_rd     = r_acc[w_idx];

    // One extra bit of headroom so the sum never wraps before clamping.
    assign w_acc_ext   = (ACC_W+1)'($signed(w_acc_rd));
    assign w_delta_ext = (ACC_W+1)'($signed(in_delta));
    assign w_sum       = w_acc_ext + w_delta_ext;
    assign w_operand   = (w_op == OP_LOAD) ? w_delta_ext : w_sum;

    // limit is ACC_W-1 bits wide, so it never exceeds the largest positive accumulator value.
    sat_clamp_unit #(
        .ACC_W      (ACC_W)
    ) u_clamp (
        .i_value    (w_operand),
        .i_eff_lim  (limit),
        .o_result_c (w_clamp_res),
        .o_hi_c     (w_clamp_hi),
        .o_lo_c     (w_clamp_lo)
    );

    // Per-op result and write enable.
    always_comb begin
        w_new    = w_acc_rd;
        w_new_hi = 1'b0;
        w_new_lo = 1'b0;
        w_write  = 1'b0;
        case (w_op)
            OP_ADD, OP_LOAD: begin
                w_new    = w_clamp_res;
                w_new_hi = w_clamp_hi;
                w_new_lo = w_clamp_lo;
                w_write  = 1'b1;
            end
            OP_CLEAR: begin
                w_new   = '0;
                w_write = 1'b1;
            end
            default: ;
        endcase
    end

    // Accumulator array: no reset, zeroed by the sweep so it can map to LUTRAM.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_sweep_we) begin
                r_acc[w_sweep_addr] <= '0;
            end else if (w_hit && w_write) begin
                r_acc[w_idx] <= w_new;
            end
        end
    end

    // Result registers: updated together with the accumulator on a transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_ch     <= '0;
            r_out_result <= '0;
            r_out_sat_hi <= 1'b0;
            r_out_sat_lo <= 1'b0;
        end else begin
            r_out_valid <= w_hit;
            if (w_hit) begin
                r_out_ch     <= in_ch;
                r_out_result <= w_new;
                r_out_sat_hi <= w_new_hi;
                r_out_sat_lo <= w_new_lo;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_ch     = r_out_ch;
    assign out_result = r_out_result;
    assign out_sat_hi = r_out_sat_hi;
    assign out_sat_lo = r_out_sat_lo;

endmodule

// File: tb/tb_sat_integrator_mc.sv
// Directed bench for sat_integrator_mc with a behavioural channel model and literal spot checks.
module tb_sat_integrator_mc;
    import integ_pkg::*;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 32;
    localparam int ACC_W  = 32;
    localparam int CH_W   = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [CH_W-1:0]   in_ch;
    logic [1:0]        in_op;
    logic [DATA_W-1:0] in_delta;
    logic [ACC_W-2:0]  limit;
    logic              clear_all;
    logic              out_valid;
    logic [CH_W-1:0]   out_ch;
    logic [ACC_W-1:0]  out_result;
    logic              out_sat_hi;
    logic              out_sat_lo;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    sat_integrator_mc dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ch      (in_ch),
        .in_op      (in_op),
        .in_delta   (in_delta),
        .limit      (limit),
        .clear_all  (clear_all),
        .out_valid  (out_valid),
        .out_ch     (out_ch),
        .out_result (out_result),
        .out_sat_hi (out_sat_hi),
        .out_sat_lo (out_sat_lo)
    );

    task automatic check(input string name, input longint act, input longint exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: channel values as plain integers, busy = cycles until accepting.
    longint m_acc [NUM_CH];
    int     m_busy    = 0;
    bit     m_started = 0;
    bit     e_valid   = 0;
    bit     e_chk     = 0;
    int     e_ch      = 0;
    longint e_res     = 0;
    bit     e_hi      = 0;
    bit     e_lo      = 0;

    always @(posedge clk) begin : model
        longint lim;
        longint pre;
        bit     xfer;
        if (rst) begin
            m_started = 1;
            m_busy    = NUM_CH;
            e_valid = 0; e_chk = 1; e_ch = 0; e_res = 0; e_hi = 0; e_lo = 0;
            for (int i = 0; i < NUM_CH; i++) m_acc[i] = 0;
        end else if (m_started) begin
            xfer    = in_valid && (m_busy == 0) && !clear_all;
            e_valid = 0;
            e_chk   = 0;
            if (clear_all) begin
                m_busy = NUM_CH;
                for (int i = 0; i < NUM_CH; i++) m_acc[i] = 0;
            end else if (m_busy > 0) begin
                m_busy--;
            end
            if (xfer && (int'(in_ch) < NUM_CH)) begin
                lim     = longint'(limit);
                e_valid = 1; e_chk = 1; e_ch = int'(in_ch); e_hi = 0; e_lo = 0;
                case (in_op)
                    2'b00, 2'b01: begin
                        pre = longint'($signed(in_delta));
                        if (in_op == 2'b00) pre = pre + m_acc[in_ch];
                        if (pre > lim) begin
                            e_res = lim; e_hi = 1;
                        end else if (pre < -lim) begin
                            e_res = -lim; e_lo = 1;
                        end else begin
                            e_res = pre;
                        end
                        m_acc[in_ch] = e_res;
                    end
                    2'b10: begin
                        m_acc[in_ch] = 0;
                        e_res = 0;
                    end
                    default: e_res = m_acc[in_ch];
                endcase
            end
        end
    end

    // Compare DUT against the model every cycle once out of reset.
    always @(negedge clk) begin
        if (m_started && !rst) begin
            check("in_ready", longint'(in_ready), longint'((m_busy == 0) && !clear_all));
            check("out_valid", longint'(out_valid), longint'(e_valid));
            if (e_chk) begin
                check("out_ch", longint'(out_ch), longint'(e_ch));
                check("out_result", longint'($signed(out_result)), e_res);
                check("out_sat_hi", longint'(out_sat_hi), longint'(e_hi));
                check("out_sat_lo", longint'(out_sat_lo), longint'(e_lo));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(input logic [1:0] op, input int ch, input longint d);
        int n;
        n        = 0;
        in_op    = op;
        in_ch    = CH_W'(ch);
        in_delta = DATA_W'(d);
        in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check("xfer_ready", longint'(in_ready), 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic expect_out(input string name, input longint res, input bit hi, input bit lo);
        check({name, "_valid"}, longint'(out_valid), 1);
        check({name, "_result"}, longint'($signed(out_result)), res);
        check({name, "_hi"}, longint'(out_sat_hi), longint'(hi));
        check({name, "_lo"}, longint'(out_sat_lo), longint'(lo));
    endtask

    task automatic expect_sweep(input string name);
        for (int i = 0; i < NUM_CH; i++) begin
            check(name, longint'(in_ready), 0);
            tick();
        end
        check({name, "_done"}, longint'(in_ready), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; clear_all = 1'b0;
        in_ch = '0; in_op = 2'b00; in_delta = '0; limit = 31'd10240000;
        tick();
        tick();
        rst = 1'b0;
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_out_result", longint'($signed(out_result)), 0);
        expect_sweep("t1_sweep");
        for (int c = 0; c < NUM_CH; c++) begin
            xfer(OP_READ, c, 0);
            expect_out("t1_read", 0, 0, 0);
            check("t1_read_ch", longint'(out_ch), longint'(c));
        end

        // Anti-windup on ch1
        xfer(OP_ADD, 1, 10000000);   expect_out("t2_a", 10000000, 0, 0);
        xfer(OP_ADD, 1, 500000);     expect_out("t2_b", 10240000, 1, 0);
        xfer(OP_ADD, 1, -300000);    expect_out("t2_c", 9940000, 0, 0);

        // Negative bound, exceeded and exact
        xfer(OP_ADD, 2, -10240001);  expect_out("t3_a", -10240000, 0, 1);
        xfer(OP_ADD, 3, -10240000);  expect_out("t3_b", -10240000, 0, 0);

        // Full-scale limit: no wrap; back-to-back accumulation
        limit = 31'h7FFF_FFFF;
        xfer(OP_LOAD, 0, 64'h7FFF_FFF0); expect_out("t4_load", 64'h7FFF_FFF0, 0, 0);
        xfer(OP_ADD, 0, 32);             expect_out("t4_add", 64'h7FFF_FFFF, 1, 0);
        xfer(OP_CLEAR, 0, 0);            expect_out("t4_clr", 0, 0, 0);
        xfer(OP_ADD, 0, 5);              expect_out("t4_b2b1", 5, 0, 0);
        xfer(OP_ADD, 0, 5);              expect_out("t4_b2b2", 10, 0, 0);
        xfer(OP_ADD, 0, 5);              expect_out("t4_b2b3", 15, 0, 0);

        // Zero limit
        limit = '0;
        xfer(OP_ADD, 1, 3);          expect_out("lim0_add", 0, 1, 0);
        xfer(OP_LOAD, 1, 0);         expect_out("lim0_load0", 0, 0, 0);
        xfer(OP_LOAD, 1, -7);        expect_out("lim0_loadn", 0, 0, 1);

        // Reduced limit leaves stored value until the next ADD
        limit = 31'd100;
        xfer(OP_READ, 2, 0);         expect_out("red_read", -10240000, 0, 0);
        xfer(OP_ADD, 2, 0);          expect_out("red_add", -100, 0, 1);

        // clear_all beats a concurrent request
        limit = 31'd10240000;
        in_op = OP_ADD; in_ch = 3'd1; in_delta = 32'd1; in_valid = 1'b1; clear_all = 1'b1;
        #1;
        check("t5_ready_clr", longint'(in_ready), 0);
        tick();
        in_valid = 1'b0; clear_all = 1'b0;
        check("t5_no_valid", longint'(out_valid), 0);
        expect_sweep("t5_sweep");
        for (int c = 0; c < NUM_CH; c++) begin
            xfer(OP_READ, c, 0);
            expect_out("t5_read", 0, 0, 0);
        end

        // Reset in the middle of a sweep restarts it
        clear_all = 1'b1;
        tick();
        clear_all = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_sweep("t5_rst_sweep");

        // Out-of-range channel is accepted but ignored
        xfer(OP_LOAD, 1, 77);        expect_out("t6_load", 77, 0, 0);
        xfer(OP_ADD, 5, 1000);
        check("t6_no_valid", longint'(out_valid), 0);
        xfer(OP_READ, 1, 0);         expect_out("t6_ch1", 77, 0, 0);
        xfer(OP_READ, 0, 0);         expect_out("t6_ch0", 0, 0, 0);
        xfer(OP_READ, 2, 0);         expect_out("t6_ch2", 0, 0, 0);
        xfer(OP_READ, 3, 0);         expect_out("t6_ch3", 0, 0, 0);

        tick();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
